// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and
// the per-entry flag record stored next to each buffered result.
package logic_unit_pipe_pkg;

  localparam int NUM_OPS = 16;

  typedef enum logic [3:0] {
    OP_NAND2 = 4'd0,
    OP_NAND3 = 4'd1,
    OP_NAND4 = 4'd2,
    OP_AND2  = 4'd3,
    OP_AND3  = 4'd4,
    OP_AND4  = 4'd5,
    OP_NOR2  = 4'd6,
    OP_NOR3  = 4'd7,
    OP_NOR4  = 4'd8,
    OP_OR2   = 4'd9,
    OP_OR3   = 4'd10,
    OP_OR4   = 4'd11,
    OP_XOR2  = 4'd12,
    OP_XNOR2 = 4'd13,
    OP_INV   = 4'd14,
    OP_PASS  = 4'd15
  } op_e;

  // Flags travel with the data so the head entry never needs a recompute.
  typedef struct packed {
    logic zero;
    logic ones;
  } flags_t;

endpackage

// File: rtl/logic_op_nbit.sv
// Purely combinational N-bit op-select datapath: builds every gate result in
// parallel, picks one with a 16:1 mux and derives the zero/all-ones flags.
module logic_op_nbit
  import logic_unit_pipe_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  output logic [N-1:0] res,
  output flags_t       flags
);

  logic [N-1:0] w_and2, w_and3, w_and4;
  logic [N-1:0] w_or2, w_or3, w_or4;
  logic [N-1:0] w_xor2;
  logic [N-1:0] w_cand [NUM_OPS];

  // Wider gates reuse the narrower partial products, bit positions stay independent.
  assign w_and2 = in0 & in1;
  assign w_and3 = w_and2 & in2;
  assign w_and4 = w_and3 & in3;
  assign w_or2  = in0 | in1;
  assign w_or3  = w_or2 | in2;
  assign w_or4  = w_or3 | in3;
  assign w_xor2 = in0 ^ in1;

  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch is inferred.
  always_comb begin
    w_cand[OP_NAND2] = ~w_and2;
    w_cand[OP_NAND3] = ~w_and3;
    w_cand[OP_NAND4] = ~w_and4;
    w_cand[OP_AND2]  = w_and2;
    w_cand[OP_AND3]  = w_and3;
    w_cand[OP_AND4]  = w_and4;
    w_cand[OP_NOR2]  = ~w_or2;
    w_cand[OP_NOR3]  = ~w_or3;
    w_cand[OP_NOR4]  = ~w_or4;
    w_cand[OP_OR2]   = w_or2;
    w_cand[OP_OR3]   = w_or3;
    w_cand[OP_OR4]   = w_or4;
    w_cand[OP_XOR2]  = w_xor2;
    w_cand[OP_XNOR2] = ~w_xor2;
    w_cand[OP_INV]   = ~in0;
    w_cand[OP_PASS]  = in0;
  end

  assign res        = w_cand[op];
  assign flags.zero = ~|res;
  assign flags.ones = &res;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a 2-entry valid/ready output buffer, stored result
// flags and a wrapping count of delivered results.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [N-1:0]     in0,
  input  logic [N-1:0]     in1,
  input  logic [N-1:0]     in2,
  input  logic [N-1:0]     in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] txn_count
);

  typedef struct packed {
    logic [N-1:0] data;
    flags_t       flags;
  } entry_t;

  logic [N-1:0]     w_res;
  flags_t           w_flags;
  entry_t           w_new;
  logic             w_push;
  logic             w_pop;

  entry_t           r_ent [2];
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_txn;

  logic_op_nbit #(.N(N)) u_op (
    .op    (op),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .res   (w_res),
    .flags (w_flags)
  );

  assign w_new = '{data: w_res, flags: w_flags};

  // Readiness looks only at occupancy, never at out_ready, to keep the
  // consumer's ready off the producer's timing path.
  assign in_ready  = (r_count < 2'd2) & ~rst;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Entry 0 is always the head; entry 1 only ever holds the second result.
  // NOTE: the buffer entries are reset too, because the head is visible on
  // out_data and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_txn   <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          r_ent[r_count[0]] <= w_new;
          r_count           <= r_count + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves it in place as the stale head.
          if (r_count == 2'd2) r_ent[0] <= r_ent[1];
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_ent[0] <= w_new;
        end
        default: begin
        end
      endcase
      if (w_pop) r_txn <= r_txn + CNT_W'(1);
    end
  end

  assign out_data  = r_ent[0].data;
  assign out_zero  = r_ent[0].flags.zero;
  assign out_ones  = r_ent[0].flags.ones;
  assign txn_count = r_txn;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_logic_unit_pipe;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [N-1:0]     in0, in1, in2, in3;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] txn_count;

  logic_unit_pipe #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         z;
    logic         o;
  } ent_t;

  ent_t q[$];
  ent_t last_popped;
  int   txn;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per bit: count how many of the used operands are 1, then apply the gate rule.
  function automatic logic [N-1:0] ref_op(input int o, input logic [N-1:0] a, b, c, d);
    logic [N-1:0] r;
    int k, cnt;
    if (o == 1 || o == 4 || o == 7 || o == 10)      k = 3;
    else if (o == 2 || o == 5 || o == 8 || o == 11) k = 4;
    else                                            k = 2;
    for (int i = 0; i < N; i++) begin
      cnt = int'(a[i]) + int'(b[i]);
      if (k >= 3) cnt += int'(c[i]);
      if (k == 4) cnt += int'(d[i]);
      case (o)
        0, 1, 2:   r[i] = (cnt != k);
        3, 4, 5:   r[i] = (cnt == k);
        6, 7, 8:   r[i] = (cnt == 0);
        9, 10, 11: r[i] = (cnt != 0);
        12:        r[i] = (cnt == 1);
        13:        r[i] = (cnt != 1);
        14:        r[i] = ~a[i];
        default:   r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance it at posedge.
  task automatic step(input logic r, input logic v, input logic [3:0] o,
                      input logic [N-1:0] a, b, c, d, input logic ordy);
    logic exp_ready, push, pop;
    ent_t head, e;
    @(negedge clk);
    rst = r; in_valid = v; op = o; in0 = a; in1 = b; in2 = c; in3 = d; out_ready = ordy;
    #1;
    exp_ready = !r && (q.size() < 2);
    head = (q.size() > 0) ? q[0] : last_popped;
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("out_data",  32'(out_data),  32'(head.d));
    check("out_zero",  32'(out_zero),  32'(head.z));
    check("out_ones",  32'(out_ones),  32'(head.o));
    check("txn_count", 32'(txn_count), 32'(txn));
    push = v && exp_ready;
    pop  = !r && (q.size() > 0) && ordy;
    e.d = ref_op(int'(o), a, b, c, d);
    e.z = (e.d == '0);
    e.o = (e.d == '1);
    @(posedge clk);
    if (r) begin
      q.delete();
      last_popped = '{d: '0, z: 1'b0, o: 1'b0};
      txn = 0;
    end else begin
      if (pop) begin
        last_popped = q.pop_front();
        txn = (txn + 1) % (1 << CNT_W);
      end
      if (push) q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 4'd0, '0, '0, '0, '0, ordy);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    out_ready = 1'b0;
    q.delete();
    last_popped = '{d: '0, z: 1'b0, o: 1'b0};
    txn = 0;

    step(1'b1, 1'b0, 4'd0, '0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 4'd0, '0, '0, '0, '0, 1'b0);
    idle(1'b0);

    // NAND3 single push
    step(1'b0, 1'b1, 4'd1, 4'b1011, 4'b1110, 4'b1101, 4'b0000, 1'b1);
    #1;
    check("nand3_valid", 32'(out_valid), 32'd1);
    check("nand3_data",  32'(out_data),  32'(4'b0111));
    check("nand3_flags", 32'({out_zero, out_ones}), 32'd0);
    idle(1'b1);
    #1 check("nand3_txn", 32'(txn_count), 32'd1);

    // XOR2 then NOR2 back to back
    step(1'b0, 1'b1, 4'd12, 4'b1010, 4'b1100, 4'b0000, 4'b0000, 1'b1);
    #1 check("xor2_data", 32'(out_data), 32'(4'b0110));
    step(1'b0, 1'b1, 4'd6, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    #1;
    check("nor2_data", 32'(out_data), 32'(4'b0000));
    check("nor2_zero", 32'(out_zero), 32'd1);
    check("b2b_ready", 32'(in_ready), 32'd1);
    idle(1'b1);

    // Backpressure fill, rejected third push, then full-plus-pop
    step(1'b0, 1'b1, 4'd15, 4'b0001, '0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 4'd15, 4'b0010, '0, '0, '0, 1'b0);
    #1 check("full_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 4'd15, 4'b0011, '0, '0, '0, 1'b0);
    #1 check("held_data", 32'(out_data), 32'(4'b0001));
    step(1'b0, 1'b1, 4'd15, 4'b0011, '0, '0, '0, 1'b1);
    #1 check("after_pop_ready", 32'(in_ready), 32'd1);
    check("after_pop_data", 32'(out_data), 32'(4'b0010));
    step(1'b0, 1'b1, 4'd15, 4'b0011, '0, '0, '0, 1'b1);
    #1 check("third_data", 32'(out_data), 32'(4'b0011));
    idle(1'b1);
    idle(1'b1);

    // Reset mid-operation with two entries held
    step(1'b0, 1'b1, 4'd3, 4'b1111, 4'b0110, '0, '0, 1'b0);
    step(1'b0, 1'b1, 4'd9, 4'b0000, 4'b0000, '0, '0, 1'b0);
    step(1'b1, 1'b1, 4'd15, 4'b1111, '0, '0, '0, 1'b1);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_txn",   32'(txn_count), 32'd0);
    step(1'b0, 1'b1, 4'd14, 4'b0101, '0, '0, '0, 1'b1);
    #1 check("inv_data", 32'(out_data), 32'(4'b1010));
    idle(1'b1);

    // Random traffic, with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 4'($urandom),
           N'($urandom), N'($urandom), N'($urandom), N'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
